// File: rtl/func_hdl_axis_join_adapter_pkg.sv
// Shared constants and types for the TyBEC kernel stream adapter.
// The default lane width follows the kernel's vectorisation factor.
package func_hdl_pkg;

  localparam int TY_GVECT       = 2;
  localparam int DEF_DATA_WIDTH = 32 * TY_GVECT;

  typedef logic [DEF_DATA_WIDTH-1:0] vect_t;

  // Bits needed to hold an occupancy value from 0 to depth inclusive.
  function automatic int cnt_bits(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/func_hdl_axis_join_adapter_fifo.sv
// Synchronous FIFO with a registered occupancy count; full/empty come straight from that count.
// Push and pop in the same cycle leave the count unchanged.
module ty_sync_fifo
  import func_hdl_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_bits(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; clearing the pointers and count is enough to empty the FIFO,
  // and leaving the array unreset lets it map onto plain RAM/SRL cells.
  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/func_hdl_axis_join_adapter.sv
// AXI-Stream <-> TyBEC kernel adapter: per-channel input FIFOs joined into one kernel beat,
// an output FIFO isolating the kernel from AXI back-pressure, and beat counters.
module func_hdl_axis_join_adapter
  import func_hdl_pkg::*;
#(
  parameter int C_DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int C_NUM_CHANNELS = 2,
  parameter int C_IN_DEPTH     = 2,
  parameter int C_OUT_DEPTH    = 4
) (
  input  logic                                         aclk,
  input  logic                                         areset,
  input  logic [C_NUM_CHANNELS-1:0]                    s_tvalid,
  input  logic [C_NUM_CHANNELS-1:0][C_DATA_WIDTH-1:0]  s_tdata,
  output logic [C_NUM_CHANNELS-1:0]                    s_tready,
  output logic                                         m_tvalid,
  output logic [C_DATA_WIDTH-1:0]                      m_tdata,
  input  logic                                         m_tready,
  output logic                                         k_ivalid,
  output logic [C_NUM_CHANNELS-1:0][C_DATA_WIDTH-1:0]  k_idata,
  input  logic                                         k_iready,
  input  logic                                         k_ovalid,
  input  logic [C_DATA_WIDTH-1:0]                      k_odata,
  output logic                                         k_oready,
  output logic [31:0]                                  in_beats,
  output logic [31:0]                                  out_beats
);

  logic [C_NUM_CHANNELS-1:0] in_full;
  logic [C_NUM_CHANNELS-1:0] in_empty;
  logic                      join_fire;
  logic                      out_full;
  logic                      out_empty;
  logic                      out_fire;

  // Handshake outputs are forced low while reset is held so no beat completes in a reset cycle.
  assign s_tready  = ~in_full & {C_NUM_CHANNELS{~areset}};
  assign k_ivalid  = ~(|in_empty) & ~areset;
  assign join_fire = k_ivalid & k_iready;

  for (genvar g = 0; g < C_NUM_CHANNELS; g++) begin : g_in
    ty_sync_fifo #(
      .WIDTH (C_DATA_WIDTH),
      .DEPTH (C_IN_DEPTH)
    ) u_in_fifo (
      .aclk   (aclk),
      .areset (areset),
      .push   (s_tvalid[g] & s_tready[g]),
      .wdata  (s_tdata[g]),
      .pop    (join_fire),
      .rdata  (k_idata[g]),
      .full   (in_full[g]),
      .empty  (in_empty[g])
    );
  end

  assign k_oready = ~out_full & ~areset;
  assign m_tvalid = ~out_empty & ~areset;
  assign out_fire = m_tvalid & m_tready;

  ty_sync_fifo #(
    .WIDTH (C_DATA_WIDTH),
    .DEPTH (C_OUT_DEPTH)
  ) u_out_fifo (
    .aclk   (aclk),
    .areset (areset),
    .push   (k_ovalid & k_oready),
    .wdata  (k_odata),
    .pop    (out_fire),
    .rdata  (m_tdata),
    .full   (out_full),
    .empty  (out_empty)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      in_beats  <= '0;
      out_beats <= '0;
    end else begin
      if (join_fire) in_beats  <= in_beats + 32'd1;
      if (out_fire)  out_beats <= out_beats + 32'd1;
    end
  end

endmodule

// File: tb/tb_func_hdl_axis_join_adapter.sv
// Bench for the stream join adapter: a 2-channel/64-bit instance with a summing loopback kernel
// and a 4-channel/128-bit instance under random valid/ready, both checked against scoreboards.
module tb_func_hdl_axis_join_adapter;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- instance A: 2 channels x 64 bits ----------------
  logic [1:0]       s_tvalid_a, s_tready_a;
  logic [1:0][63:0] s_tdata_a, k_idata_a;
  logic             m_tvalid_a, m_tready_a, k_ivalid_a, k_iready_a, k_ovalid_a, k_oready_a;
  logic [63:0]      m_tdata_a, k_odata_a;
  logic [31:0]      in_beats_a, out_beats_a;
  logic [1:0]       en_a = '0;
  logic             ken_a = 1'b1;
  int               lim_a = 0;
  int               idx_a [2];

  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      s_tvalid_a[ch] = en_a[ch] && (idx_a[ch] < lim_a);
      s_tdata_a[ch]  = 64'(ch * 100 + idx_a[ch]);
    end
  end

  assign k_iready_a = k_oready_a & ken_a;
  assign k_ovalid_a = k_ivalid_a & ken_a;
  assign k_odata_a  = k_idata_a[0] + k_idata_a[1];

  func_hdl_axis_join_adapter #(
    .C_DATA_WIDTH(64), .C_NUM_CHANNELS(2), .C_IN_DEPTH(2), .C_OUT_DEPTH(4)
  ) dut_a (
    .aclk(aclk), .areset(areset),
    .s_tvalid(s_tvalid_a), .s_tdata(s_tdata_a), .s_tready(s_tready_a),
    .m_tvalid(m_tvalid_a), .m_tdata(m_tdata_a), .m_tready(m_tready_a),
    .k_ivalid(k_ivalid_a), .k_idata(k_idata_a), .k_iready(k_iready_a),
    .k_ovalid(k_ovalid_a), .k_odata(k_odata_a), .k_oready(k_oready_a),
    .in_beats(in_beats_a), .out_beats(out_beats_a)
  );

  // ---------------- instance B: 4 channels x 128 bits ----------------
  logic [3:0]        s_tvalid_b, s_tready_b;
  logic [3:0][127:0] s_tdata_b, k_idata_b;
  logic              m_tvalid_b, m_tready_b, k_ivalid_b, k_iready_b, k_ovalid_b, k_oready_b;
  logic [127:0]      m_tdata_b, k_odata_b;
  logic [31:0]       in_beats_b, out_beats_b;
  logic [3:0]        rv_b = '0;
  logic              ken_b = 1'b1;
  int                lim_b = 0;
  int                idx_b [4];

  always_comb begin
    for (int ch = 0; ch < 4; ch++) begin
      s_tvalid_b[ch] = rv_b[ch] && (idx_b[ch] < lim_b);
      s_tdata_b[ch]  = {32'(idx_b[ch]) * 32'h9E37_79B1, 32'(ch << 24) | 32'(idx_b[ch]),
                        ~32'(idx_b[ch]), 32'(idx_b[ch])};
    end
  end

  assign k_iready_b = k_oready_b & ken_b;
  assign k_ovalid_b = k_ivalid_b & ken_b;
  assign k_odata_b  = k_idata_b[0] + k_idata_b[1] + k_idata_b[2] + k_idata_b[3];

  func_hdl_axis_join_adapter #(
    .C_DATA_WIDTH(128), .C_NUM_CHANNELS(4), .C_IN_DEPTH(2), .C_OUT_DEPTH(4)
  ) dut_b (
    .aclk(aclk), .areset(areset),
    .s_tvalid(s_tvalid_b), .s_tdata(s_tdata_b), .s_tready(s_tready_b),
    .m_tvalid(m_tvalid_b), .m_tdata(m_tdata_b), .m_tready(m_tready_b),
    .k_ivalid(k_ivalid_b), .k_idata(k_idata_b), .k_iready(k_iready_b),
    .k_ovalid(k_ovalid_b), .k_odata(k_odata_b), .k_oready(k_oready_b),
    .in_beats(in_beats_b), .out_beats(out_beats_b)
  );

  // Source beat indices advance on each accepted beat; reset restarts every stream at 0.
  always @(posedge aclk) begin
    for (int ch = 0; ch < 2; ch++)
      if (areset) idx_a[ch] <= 0;
      else if (s_tvalid_a[ch] && s_tready_a[ch]) idx_a[ch] <= idx_a[ch] + 1;
    for (int ch = 0; ch < 4; ch++)
      if (areset) idx_b[ch] <= 0;
      else if (s_tvalid_b[ch] && s_tready_b[ch]) idx_b[ch] <= idx_b[ch] + 1;
  end

  // ---------------- scoreboards (sampled mid-cycle, record the coming edge) ----------------
  logic [63:0]  qa [2][$];
  logic [63:0]  exp_a [$];
  logic [127:0] qb [4][$];
  logic [127:0] exp_b [$];
  logic              prev_stall_b = 1'b0;
  logic [3:0][127:0] prev_kd_b;

  always @(negedge aclk) begin
    if (areset) begin
      for (int ch = 0; ch < 2; ch++) qa[ch].delete();
      exp_a.delete();
    end else begin
      for (int ch = 0; ch < 2; ch++)
        if (s_tvalid_a[ch] && s_tready_a[ch]) qa[ch].push_back(s_tdata_a[ch]);
      while (qa[0].size() > 0 && qa[1].size() > 0)
        exp_a.push_back(qa[0].pop_front() + qa[1].pop_front());
      if (m_tvalid_a && m_tready_a) begin
        if (exp_a.size() == 0) begin
          total++;
          bad++;
          $display("FAIL a_sb: got unexpected beat %0h expected none", m_tdata_a);
        end else begin
          check("a_sb", 128'(m_tdata_a), 128'(exp_a.pop_front()));
        end
      end
    end
  end

  always @(negedge aclk) begin
    if (areset) begin
      for (int ch = 0; ch < 4; ch++) qb[ch].delete();
      exp_b.delete();
      prev_stall_b <= 1'b0;
    end else begin
      if (prev_stall_b) check("b_kdata_hold", 128'(k_idata_b == prev_kd_b), 128'(1));
      prev_stall_b <= k_ivalid_b & ~k_iready_b;
      prev_kd_b    <= k_idata_b;
      for (int ch = 0; ch < 4; ch++)
        if (s_tvalid_b[ch] && s_tready_b[ch]) qb[ch].push_back(s_tdata_b[ch]);
      while (qb[0].size() > 0 && qb[1].size() > 0 && qb[2].size() > 0 && qb[3].size() > 0)
        exp_b.push_back(qb[0].pop_front() + qb[1].pop_front() + qb[2].pop_front() + qb[3].pop_front());
      if (m_tvalid_b && m_tready_b) begin
        if (exp_b.size() == 0) begin
          total++;
          bad++;
          $display("FAIL b_sb: got unexpected beat %0h expected none", m_tdata_b);
        end else begin
          check("b_sb", m_tdata_b, exp_b.pop_front());
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    @(posedge aclk); #1 areset = 1'b1;
    @(posedge aclk); #1 areset = 1'b0;
  endtask

  task automatic wait_beats(input bit use_b, input int target, input int budget, input string name);
    int c = 0;
    while ((use_b ? out_beats_b : out_beats_a) < 32'(target) && c < budget) begin
      @(negedge aclk);
      c++;
    end
    check(name, 128'(use_b ? out_beats_b : out_beats_a), 128'(target));
  endtask

  typedef struct {
    logic [1:0] vld;
    logic [1:0] rdy;
    logic       kiv;
    logic       mtv;
    int         ib;
    int         ob;
  } vec_t;

  initial begin
    vec_t tbl [11];
    int   k, first, last;
    bit   seen;

    tbl[0]  = '{2'b01, 2'b11, 1'b0, 1'b0, 0, 0};
    tbl[1]  = '{2'b01, 2'b11, 1'b0, 1'b0, 0, 0};
    tbl[2]  = '{2'b01, 2'b10, 1'b0, 1'b0, 0, 0};
    tbl[3]  = '{2'b10, 2'b10, 1'b0, 1'b0, 0, 0};
    tbl[4]  = '{2'b00, 2'b10, 1'b1, 1'b0, 0, 0};
    tbl[5]  = '{2'b00, 2'b11, 1'b0, 1'b1, 1, 0};
    tbl[6]  = '{2'b11, 2'b11, 1'b0, 1'b0, 1, 1};
    tbl[7]  = '{2'b11, 2'b10, 1'b1, 1'b0, 1, 1};
    tbl[8]  = '{2'b00, 2'b11, 1'b1, 1'b1, 2, 1};
    tbl[9]  = '{2'b00, 2'b11, 1'b0, 1'b1, 3, 2};
    tbl[10] = '{2'b00, 2'b11, 1'b0, 1'b0, 3, 3};

    m_tready_a = 1'b1;
    m_tready_b = 1'b1;
    lim_a = 16;

    // Reset held three cycles with all sources valid.
    en_a = 2'b11;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check("rst_s_tready", 128'(s_tready_a), 128'(0));
    check("rst_m_tvalid", 128'(m_tvalid_a), 128'(0));
    check("rst_k_ivalid", 128'(k_ivalid_a), 128'(0));
    check("rst_k_oready", 128'(k_oready_a), 128'(0));
    check("rst_in_beats", 128'(in_beats_a), 128'(0));
    check("rst_out_beats", 128'(out_beats_a), 128'(0));
    @(posedge aclk); #1;
    areset = 1'b0;
    en_a = 2'b00;
    @(negedge aclk);
    check("rst_ready_after", 128'(s_tready_a), 128'(2'b11));

    // Cycle-by-cycle vectors: fill, full, join, same-cycle push/pop.
    for (int r = 0; r < 11; r++) begin
      @(posedge aclk); #1;
      en_a = tbl[r].vld;
      @(negedge aclk);
      check($sformatf("vec%0d_s_tready", r), 128'(s_tready_a), 128'(tbl[r].rdy));
      check($sformatf("vec%0d_k_ivalid", r), 128'(k_ivalid_a), 128'(tbl[r].kiv));
      check($sformatf("vec%0d_m_tvalid", r), 128'(m_tvalid_a), 128'(tbl[r].mtv));
      check($sformatf("vec%0d_in_beats", r), 128'(in_beats_a), 128'(tbl[r].ib));
      check($sformatf("vec%0d_out_beats", r), 128'(out_beats_a), 128'(tbl[r].ob));
    end

    // Streaming: 16 beats per channel, sums 100+2i in order, one beat per cycle once filled.
    do_reset();
    lim_a = 16;
    en_a = 2'b11;
    k = 0; first = 0; last = 0;
    for (int c = 0; c < 200 && k < 16; c++) begin
      @(negedge aclk);
      if (m_tvalid_a && m_tready_a) begin
        check("stream_data", 128'(m_tdata_a), 128'(100 + 2 * k));
        if (k == 0) first = c;
        last = c;
        k++;
      end
    end
    @(negedge aclk);
    check("stream_count", 128'(k), 128'(16));
    check("stream_rate", 128'(last - first), 128'(15));
    check("stream_in_beats", 128'(in_beats_a), 128'(16));
    check("stream_out_beats", 128'(out_beats_a), 128'(16));
    en_a = 2'b00;

    // Skew: channel 1 starts five cycles late.
    do_reset();
    lim_a = 8;
    for (int c = 0; c < 8; c++) begin
      en_a = (c < 5) ? 2'b01 : 2'b11;
      @(negedge aclk);
      if (c <= 5) check($sformatf("skew_k_ivalid_c%0d", c), 128'(k_ivalid_a), 128'(0));
      if (c < 5)  check($sformatf("skew_ready0_c%0d", c), 128'(s_tready_a[0]), 128'(c < 2));
      @(posedge aclk); #1;
    end
    wait_beats(1'b0, 8, 200, "skew_out_beats");
    @(negedge aclk);
    check("skew_in_beats", 128'(in_beats_a), 128'(8));
    en_a = 2'b00;

    // Back-pressure: sink stalls ten cycles, output FIFO fills after four beats.
    do_reset();
    lim_a = 12;
    en_a = 2'b11;
    m_tready_a = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge aclk);
      check($sformatf("bp_k_oready_c%0d", c), 128'(k_oready_a), 128'(c < 5));
      @(posedge aclk); #1;
    end
    check("bp_out_beats_stalled", 128'(out_beats_a), 128'(0));
    m_tready_a = 1'b1;
    wait_beats(1'b0, 12, 200, "bp_out_beats");
    @(negedge aclk);
    check("bp_in_beats", 128'(in_beats_a), 128'(12));
    en_a = 2'b00;

    // Mid-stream reset with data buffered everywhere.
    do_reset();
    lim_a = 20;
    en_a = 2'b11;
    m_tready_a = 1'b0;
    repeat (4) @(posedge aclk);
    #1 areset = 1'b1;
    @(negedge aclk);
    check("mrst_s_tready", 128'(s_tready_a), 128'(0));
    check("mrst_m_tvalid", 128'(m_tvalid_a), 128'(0));
    check("mrst_k_ivalid", 128'(k_ivalid_a), 128'(0));
    @(posedge aclk); #1;
    areset = 1'b0;
    m_tready_a = 1'b1;
    @(negedge aclk);
    check("mrst_in_beats", 128'(in_beats_a), 128'(0));
    check("mrst_out_beats", 128'(out_beats_a), 128'(0));
    check("mrst_m_tvalid_after", 128'(m_tvalid_a), 128'(0));
    check("mrst_k_ivalid_after", 128'(k_ivalid_a), 128'(0));
    check("mrst_s_tready_after", 128'(s_tready_a), 128'(2'b11));
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge aclk);
      if (m_tvalid_a && m_tready_a) begin
        check("mrst_first_beat", 128'(m_tdata_a), 128'(100));
        seen = 1'b1;
      end
    end
    check("mrst_first_seen", 128'(seen), 128'(1));
    wait_beats(1'b0, 20, 200, "mrst_out_beats_final");
    en_a = 2'b00;

    // Random valid/ready on every port of the 4-channel instance.
    do_reset();
    lim_b = 1000;
    for (int c = 0; c < 30000 && out_beats_b < 32'd1000; c++) begin
      for (int ch = 0; ch < 4; ch++) rv_b[ch] = ($urandom_range(3) != 0);
      ken_b      = ($urandom_range(3) != 0);
      m_tready_b = ($urandom_range(3) != 0);
      @(posedge aclk); #1;
    end
    m_tready_b = 1'b1;
    ken_b = 1'b1;
    repeat (10) @(posedge aclk);
    @(negedge aclk);
    check("rand_out_beats", 128'(out_beats_b), 128'(1000));
    check("rand_in_beats", 128'(in_beats_b), 128'(1000));
    check("rand_sb_left", 128'(exp_b.size()), 128'(0));
    check("rand_m_tvalid_idle", 128'(m_tvalid_b), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
